rom_arbiter: RTL and testbench



---
 rtl/rom_arbiter.sv | 93 +++++++++
 tb/tb_rom_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port front end for the single-ported instruction ROM.
// It grants one access per cycle, screens out invalid addresses, and returns registered responses one cycle later.
module rom_arbiter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int InstMemNum    = 1024,
    parameter int Port0Priority = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [AddrWidth-1:0] addr0,
    output logic                 gnt0,
    output logic                 stall0,
    output logic                 rvalid0,
    output logic [DataWidth-1:0] rdata0,
    output logic                 err0,
    input  logic                 req1,
    input  logic [AddrWidth-1:0] addr1,
    output logic                 gnt1,
    output logic                 stall1,
    output logic                 rvalid1,
    output logic [DataWidth-1:0] rdata1,
    output logic                 err1,
    output logic                 rom_ce,
    output logic [AddrWidth-1:0] rom_addr,
    input  logic [DataWidth-1:0] rom_inst
);

    // One extra bit keeps the limit exact even when InstMemNum fills the whole word-index range.
    localparam logic [AddrWidth-2:0] WordLimit = (AddrWidth-1)'(InstMemNum);

    logic                 ptr;
    logic [AddrWidth-1:0] sel_addr;
    logic                 addr_ok;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                if ((Port0Priority != 0) || !ptr) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign stall0 = req0 & ~gnt0;
    assign stall1 = req1 & ~gnt1;

    assign sel_addr = gnt1 ? addr1 : addr0;
    assign addr_ok  = (sel_addr[1:0] == 2'b00) &&
                      ({1'b0, sel_addr[AddrWidth-1:2]} < WordLimit);

    // The ROM is enabled only for a granted, in-range, aligned access.
    assign rom_ce   = (gnt0 | gnt1) & addr_ok;
    assign rom_addr = rom_ce ? sel_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 1'b0;
            rvalid0 <= 1'b0;
            rdata0  <= '0;
            err0    <= 1'b0;
            rvalid1 <= 1'b0;
            rdata1  <= '0;
            err1    <= 1'b0;
        end else begin
            rvalid0 <= gnt0;
            err0    <= gnt0 & ~addr_ok;
            rvalid1 <= gnt1;
            err1    <= gnt1 & ~addr_ok;
            if (gnt0) begin
                rdata0 <= addr_ok ? rom_inst : '0;
            end
            if (gnt1) begin
                rdata1 <= addr_ok ? rom_inst : '0;
            end
            if (gnt0) begin
                ptr <= 1'b1;
            end else if (gnt1) begin
                ptr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a round-robin instance and a port-0-priority instance are driven side by side.
// Expected responses are queued at grant time and retired one cycle later.
module tb_rom_arbiter;

    localparam int MemNum = 1024;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1;

    logic        rr_gnt0, rr_stall0, rr_rvalid0, rr_err0;
    logic        rr_gnt1, rr_stall1, rr_rvalid1, rr_err1;
    logic [31:0] rr_rdata0, rr_rdata1, rr_rom_addr, rr_rom_inst;
    logic        rr_rom_ce;

    logic        pri_gnt0, pri_stall0, pri_rvalid0, pri_err0;
    logic        pri_gnt1, pri_stall1, pri_rvalid1, pri_err1;
    logic [31:0] pri_rdata0, pri_rdata1, pri_rom_addr, pri_rom_inst;
    logic        pri_rom_ce;

    resp_t rr_q0[$], rr_q1[$], pri_q0[$], pri_q1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM image is 3C01_0000 | word index; a disabled ROM returns a poison value.
    assign rr_rom_inst  = rr_rom_ce  ? (32'h3C01_0000 | {22'b0, rr_rom_addr[11:2]})  : 32'hDEAD_BEEF;
    assign pri_rom_inst = pri_rom_ce ? (32'h3C01_0000 | {22'b0, pri_rom_addr[11:2]}) : 32'hDEAD_BEEF;

    rom_arbiter #(.AddrWidth(32), .DataWidth(32), .InstMemNum(MemNum), .Port0Priority(0)) dut_rr (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(rr_gnt0), .stall0(rr_stall0),
        .rvalid0(rr_rvalid0), .rdata0(rr_rdata0), .err0(rr_err0),
        .req1(req1), .addr1(addr1), .gnt1(rr_gnt1), .stall1(rr_stall1),
        .rvalid1(rr_rvalid1), .rdata1(rr_rdata1), .err1(rr_err1),
        .rom_ce(rr_rom_ce), .rom_addr(rr_rom_addr), .rom_inst(rr_rom_inst)
    );

    rom_arbiter #(.AddrWidth(32), .DataWidth(32), .InstMemNum(MemNum), .Port0Priority(1)) dut_pri (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(pri_gnt0), .stall0(pri_stall0),
        .rvalid0(pri_rvalid0), .rdata0(pri_rdata0), .err0(pri_err0),
        .req1(req1), .addr1(addr1), .gnt1(pri_gnt1), .stall1(pri_stall1),
        .rvalid1(pri_rvalid1), .rdata1(pri_rdata1), .err1(pri_err1),
        .rom_ce(pri_rom_ce), .rom_addr(pri_rom_addr), .rom_inst(pri_rom_inst)
    );

    function automatic logic addrValid(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < MemNum);
    endfunction

    function automatic resp_t expResp(input logic [31:0] a);
        resp_t r;
        r.err  = ~addrValid(a);
        r.data = addrValid(a) ? (32'h3C01_0000 | (a >> 2)) : 32'h0;
        return r;
    endfunction

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Retire one port: a queued entry demands a valid response, otherwise the port must be quiet.
    task automatic checkOutput(input string tag, input logic rv, input logic er, input logic [31:0] rd,
                               input logic have, input resp_t e);
        if (have) begin
            checkBit({tag, "_rvalid"}, rv, 1'b1);
            checkBit({tag, "_err"}, er, e.err);
            checkWord({tag, "_rdata"}, rd, e.data);
        end else begin
            checkBit({tag, "_rvalid"}, rv, 1'b0);
            checkBit({tag, "_err"}, er, 1'b0);
        end
    endtask

    // Drives one cycle, checks the combinational grant side, then retires responses after the edge.
    task automatic applyStimulus(input logic r, input logic q0, input logic [31:0] a0,
                                 input logic q1, input logic [31:0] a1,
                                 input logic e_rr0, input logic e_rr1,
                                 input logic e_pri0, input logic e_pri1);
        logic [31:0] ga;
        logic        ce;
        resp_t       e;
        logic        have;
        rst = r; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
        @(negedge clk);
        checkBit("rr_gnt0", rr_gnt0, e_rr0);
        checkBit("rr_gnt1", rr_gnt1, e_rr1);
        checkBit("rr_stall0", rr_stall0, q0 & ~e_rr0);
        checkBit("rr_stall1", rr_stall1, q1 & ~e_rr1);
        ga = e_rr1 ? a1 : a0;
        ce = (e_rr0 | e_rr1) & addrValid(ga);
        checkBit("rr_rom_ce", rr_rom_ce, ce);
        checkWord("rr_rom_addr", rr_rom_addr, ce ? ga : 32'h0);
        checkBit("pri_gnt0", pri_gnt0, e_pri0);
        checkBit("pri_gnt1", pri_gnt1, e_pri1);
        checkBit("pri_stall1", pri_stall1, q1 & ~e_pri1);
        ga = e_pri1 ? a1 : a0;
        ce = (e_pri0 | e_pri1) & addrValid(ga);
        checkBit("pri_rom_ce", pri_rom_ce, ce);
        checkWord("pri_rom_addr", pri_rom_addr, ce ? ga : 32'h0);
        if (e_rr0)  rr_q0.push_back(expResp(a0));
        if (e_rr1)  rr_q1.push_back(expResp(a1));
        if (e_pri0) pri_q0.push_back(expResp(a0));
        if (e_pri1) pri_q1.push_back(expResp(a1));
        @(posedge clk);
        #1;
        e = '{err: 1'b0, data: 32'h0};
        have = (rr_q0.size() > 0);
        if (have) e = rr_q0.pop_front();
        checkOutput("rr_p0", rr_rvalid0, rr_err0, rr_rdata0, have, e);
        have = (rr_q1.size() > 0);
        if (have) e = rr_q1.pop_front();
        checkOutput("rr_p1", rr_rvalid1, rr_err1, rr_rdata1, have, e);
        have = (pri_q0.size() > 0);
        if (have) e = pri_q0.pop_front();
        checkOutput("pri_p0", pri_rvalid0, pri_err0, pri_rdata0, have, e);
        have = (pri_q1.size() > 0);
        if (have) e = pri_q1.pop_front();
        checkOutput("pri_p1", pri_rvalid1, pri_err1, pri_rdata1, have, e);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 32'h0; addr1 = 32'h0;
        @(posedge clk);
        #1;

        $display("[TB] reset behaviour");
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h4, 1, 32'h8, 0, 0, 0, 0);

        $display("[TB] port 0 streaming alone");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 32'(4 * i), 0, 32'h0, 1, 0, 1, 0);
        end

        $display("[TB] continuous contention");
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 32'h8, 1, 32'h10, (i % 2) == 0, (i % 2) == 1, 1, 0);
        end

        $display("[TB] invalid and boundary addresses");
        applyStimulus(0, 0, 32'h0, 1, 32'h6, 0, 1, 0, 1);
        applyStimulus(0, 0, 32'h0, 1, 32'(MemNum * 4), 0, 1, 0, 1);
        applyStimulus(0, 0, 32'h0, 1, 32'((MemNum - 1) * 4), 0, 1, 0, 1);
        applyStimulus(0, 1, 32'h2, 0, 32'h0, 1, 0, 1, 0);

        $display("[TB] reset mid-operation");
        applyStimulus(0, 1, 32'h0, 0, 32'h0, 1, 0, 1, 0);
        applyStimulus(1, 1, 32'h4, 0, 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h8, 1, 32'h10, 1, 0, 1, 0);

        $display("[TB] idle cycles keep the pointer");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        end
        applyStimulus(0, 1, 32'h8, 1, 32'h10, 0, 1, 1, 0);
        applyStimulus(0, 1, 32'h8, 1, 32'h10, 1, 0, 1, 0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
